// File: rtl/configure.sv
// Shared operand widths so the divider and the multiplier are built and checked
// against the same sizes.
package configure;
  parameter int XLEN = 32;
  parameter int YLEN = 32;
endpackage

// File: rtl/div.sv
// Sequential unsigned radix-2 restoring divider: XLEN-bit dividend, YLEN-bit
// divisor, one quotient bit per cycle, results held until the next completion.
module div #(
  parameter int XLEN = configure::XLEN,
  parameter int YLEN = configure::YLEN
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] a_i,
  input  logic [YLEN-1:0] b_i,
  output logic [XLEN-1:0] q_o,
  output logic [YLEN-1:0] r_o,
  output logic            dz_o,
  output logic            done_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [YLEN-1:0] rem_q, rem_d;
  logic [YLEN-1:0] dvs_q, dvs_d;
  logic            dzp_q, dzp_d;
  logic [XLEN-1:0] q_q, q_d;
  logic [YLEN-1:0] r_q, r_d;
  logic            dz_q, dz_d;

  logic            accept;
  logic            last_iter;
  logic [YLEN:0]   shifted;
  logic [YLEN-1:0] diff;
  logic            ge;
  logic [YLEN-1:0] rem_step;
  logic [XLEN-1:0] dvd_step;

  assign accept    = (state_q == IDLE) && valid_i;
  assign last_iter = (state_q == BUSY) && (cnt_q == '0);

  // The shifted value is the full YLEN+1-bit partial remainder; after a
  // successful subtraction the result is below the divisor, so YLEN bits hold it.
  always_comb begin
    shifted  = {rem_q, dvd_q[XLEN-1]};
    ge       = shifted >= {1'b0, dvs_q};
    diff     = shifted[YLEN-1:0] - dvs_q;
    rem_step = ge ? diff : shifted[YLEN-1:0];
    dvd_step = {dvd_q[XLEN-2:0], ge};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i) state_d = BUSY;
      BUSY:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_q == IDLE);
    done_o  = (state_q == DONE);
  end

  // The dividend register doubles as the quotient collector: dividend bits
  // leave at the top while quotient bits enter at the bottom.
  always_comb begin
    cnt_d = cnt_q;
    dvd_d = dvd_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    dzp_d = dzp_q;
    q_d   = q_q;
    r_d   = r_q;
    dz_d  = dz_q;
    if (accept) begin
      cnt_d = CW'(XLEN - 1);
      dvd_d = a_i;
      rem_d = '0;
      dvs_d = b_i;
      dzp_d = (b_i == '0);
    end else if (state_q == BUSY) begin
      dvd_d = dvd_step;
      rem_d = rem_step;
      cnt_d = cnt_q - CW'(1);
      if (last_iter) begin
        cnt_d = '0;
        q_d   = dvd_step;
        r_d   = rem_step;
        dz_d  = dzp_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      dvd_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      dzp_q <= 1'b0;
      q_q   <= '0;
      r_q   <= '0;
      dz_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dvd_q <= dvd_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      dzp_q <= dzp_d;
      q_q   <= q_d;
      r_q   <= r_d;
      dz_q  <= dz_d;
    end
  end

  assign q_o  = q_q;
  assign r_o  = r_q;
  assign dz_o = dz_q;

endmodule

// File: doc/div.md
# div

Sequential unsigned radix-2 restoring divider, the inverse companion to the combinational `mul` tree multiplier. Accepts an XLEN-bit dividend and YLEN-bit divisor over a valid/ready handshake and produces quotient and remainder after a fixed number of cycles. Widths come from the `configure` package so `div` and `mul` are checked against the same operand sizes: `a == q*b + r` round-trips through `mul`.

## Interface
- `XLEN`, default from `configure`: dividend and quotient width; must be ≥ 2.
- `YLEN`, default from `configure`: divisor and remainder width; must be ≥ 1 and ≤ XLEN.
- `clock` in 1: single clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-low; asserting low forces reset state immediately.
- `valid` in 1: request; `a`/`b` are sampled when `valid & ready` at a rising edge.
- `ready` out 1: high only in IDLE.
- `a` in XLEN: dividend, unsigned.
- `b` in YLEN: divisor, unsigned.
- `q` out XLEN: quotient, registered.
- `r` out YLEN: remainder, registered.
- `dz` out 1: divide-by-zero flag for the current result, registered.
- `done` out 1: one-cycle pulse; `q`/`r`/`dz` are valid from this cycle on.

## Operation
- States: IDLE, BUSY, DONE. Reset state IDLE.
- Reset values: `ready`=1 (IDLE), `done`=0, `q`=0, `r`=0, `dz`=0, step counter 0, internal partial remainder and operand registers 0.
- IDLE: `ready`=1. On `valid`=1 at a rising edge:
  - latch `a` into the shift register and `b` into the divisor register;
  - clear the partial remainder, which is YLEN+1 bits;
  - load counter = XLEN-1;
  - go to BUSY.
  - With `valid`=0, stay in IDLE.
- BUSY: `ready`=0; `valid` is ignored and not queued. Per cycle:
  - shift the partial remainder left, bringing in the MSB of the dividend shift register;
  - trial-subtract the divisor. If non-negative, keep the difference and shift quotient bit 1 in; else restore and shift 0 in.
  - When the counter is 0 on this iteration, register results into `q`/`r`/`dz` and go to DONE; else decrement the counter.
- DONE: `done`=1, `ready`=0 for exactly one cycle, then IDLE unconditionally.
- Results hold in `q`/`r`/`dz` until the next DONE or reset. They are not cleared when a new request is accepted.
- Divide by zero (`b`=0): takes the same latency as a normal division.
  - `q` = all ones, `r` = `a[YLEN-1:0]`, `dz`=1.
  - The restoring algorithm produces exactly this naturally except for `r` truncation; `dz` is computed as `b==0` at accept.
- Otherwise `dz`=0, `q` = floor(a/b), `r` = a mod b. r < b always fits in YLEN bits.
- Reset asserted in any state aborts the operation. It returns the block to the reset values above and emits no `done`.

## Timing
- Accept at rising edge E0.
- Iterations occur at edges E1..EXLEN; results are registered at EXLEN.
- `done`=1 in the cycle between EXLEN and EXLEN+1.
- `ready` returns to 1 after EXLEN+1.
- Accept-to-done latency is XLEN cycles, and the initiation interval is XLEN+2 cycles.
- Earliest back-to-back accept is at edge EXLEN+2; `valid` may stay high continuously.
- `ready` and `done` are decoded from registered state only; there is no combinational path from `valid`, `a` or `b` to any output.
- Asynchronous reset assertion takes effect without a clock edge. Deassertion is synchronised externally; the first accept is possible on the first rising edge after deassertion.

## Test plan
Run with XLEN=YLEN=32 unless noted. The bench compares against `a/b` and `a%b`, like the `mul` bench compares against `a*b`, and prints SUCCEEDED/FAILED per result.

- `a`=100, `b`=7, valid for one cycle → after 32 cycles `done` pulses once with `q`=14, `r`=2, `dz`=0; `ready` low for exactly 33 cycles.
- `a`=0xFFFFFFFF, `b`=1 → `q`=0xFFFFFFFF, `r`=0. Also `a`=5, `b`=9 → `q`=0, `r`=5.
- `a`=0x12345678, `b`=0 → `q`=0xFFFFFFFF, `r`=0x12345678, `dz`=1.
  - With YLEN=16, `r`=0x5678.
  - A following 10/3 returns `dz`=0, `q`=3, `r`=1.
- `valid` held high with changing operands → accepts only at `ready`; each `done` matches the operands sampled at its accept edge; `a`/`b` changes during BUSY have no effect.
- Reset pulled low at iteration 10 of 1000/3 → `ready`=1, `q`=`r`=0 and `done`=0 immediately; no late `done`; the next request 1000/3 → `q`=333, `r`=1.
- 10,000 random `$urandom` operand pairs including `b`=0 and `b`>`a`, with XLEN=64, YLEN=32 and with XLEN=YLEN=32 → zero mismatches.
